imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory while holding the CPU in reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [ADDR_W:0] MAX_LEN = MAX_WORDS[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state, state_next;
  logic [ADDR_W:0] ptr, len, ptr_inc;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic            err_q;
  logic            xfer;
  logic            len_bad;

  assign xfer    = in_valid && in_ready;
  assign ptr_inc = ptr + ONE;
  assign len_bad = (num_words == '0) || (num_words > MAX_LEN);

  // NOTE: next-state logic assigns its default first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = len_bad ? S_DONE : S_LOAD;
      S_LOAD:  if (xfer && lane == 2'd3) state_next = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: state_next = (ptr_inc == len) ? S_CHECK : S_LOAD;
      S_CHECK: if (xfer) state_next = S_DONE;
`else
      S_WRITE: state_next = (ptr_inc == len) ? S_DONE : S_LOAD;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum, sum_next;
  assign sum_next = sum + in_data;
  assign in_ready = (state == S_LOAD) || (state == S_CHECK);
  assign cpu_hold = (state == S_LOAD) || (state == S_WRITE) || (state == S_CHECK);
`else
  assign in_ready = (state == S_LOAD);
  assign cpu_hold = (state == S_LOAD) || (state == S_WRITE);
`endif

  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = ptr[ADDR_W-1:0];
  assign mem_wdata = word;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      len   <= '0;
      lane  <= '0;
      word  <= '0;
      err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: if (start) begin
          len   <= num_words;
          ptr   <= '0;
          lane  <= '0;
          err_q <= (num_words > MAX_LEN);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum   <= '0;
`endif
        end
        S_LOAD: if (xfer) begin
          // Lane k lands in bits [8k+7:8k]: little-endian within the word.
          word[{lane, 3'b000} +: 8] <= in_data;
          lane                      <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum                       <= sum_next;
`endif
        end
        S_WRITE: ptr <= ptr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: if (xfer && sum_next != 8'd0) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
